// File: rtl/ssr_interrogation_encoder_if.sv
// Mode-sequencer to interrogation-encoder link: sequencer stream in, pulse drives and frame tags out.
interface ssr_interrogation_encoder_if;
    logic [3:0] mode;
    logic       oddeven;
    logic       stop;
    logic       sls_en;
    logic       p13;
    logic       p2;
    logic       busy;
    logic       done;
    logic [3:0] mode_tag;
    logic       phase_tag;
    logic       err;
    logic       overrun;

    modport master (
        output mode, oddeven, stop, sls_en,
        input  p13, p2, busy, done, mode_tag, phase_tag, err, overrun
    );

    modport slave (
        input  mode, oddeven, stop, sls_en,
        output p13, p2, busy, done, mode_tag, phase_tag, err, overrun
    );
endinterface

// File: rtl/ssr_interrogation_encoder.sv
// SSR interrogation encoder: converts the one-hot mode stream into a P1/P3 (+ optional P2)
// pulse frame per PRI slot, tagging each frame with its mode and interlace phase.
module ssr_interrogation_encoder #(
    parameter int unsigned PW     = 16,
    parameter int unsigned P2_OFF = 40,
    parameter int unsigned T1     = 60,
    parameter int unsigned T2     = 100,
    parameter int unsigned T3A    = 160,
    parameter int unsigned TC     = 420,
    parameter int unsigned CW     = 10
) (
    input  logic clk,
    input  logic rst,
    ssr_interrogation_encoder_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEmit = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [CW-1:0] PwC   = CW'(PW);
    localparam logic [CW-1:0] P2C   = CW'(P2_OFF);
    localparam logic [CW-1:0] T1C   = CW'(T1);
    localparam logic [CW-1:0] T2C   = CW'(T2);
    localparam logic [CW-1:0] T3AC  = CW'(T3A);
    localparam logic [CW-1:0] TcC   = CW'(TC);
    localparam logic [CW-1:0] One   = CW'(1);
    localparam logic [CW-1:0] Zero  = '0;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    mode_tag_q, mode_tag_d;
    logic          phase_tag_q, phase_tag_d;
    logic          sls_q, sls_d;
    logic          stop_dly_q;
    logic [3:0]    mode_prev_q;
    logic          p13_q, p13_d;
    logic          p2_q, p2_d;
    logic          err_q, err_d;
    logic          overrun_q, overrun_d;
    logic          launch, one_hot;
    logic [CW-1:0] tm_q, tm_d;

    function automatic logic [CW-1:0] t_of(input logic [3:0] m);
        case (m)
            4'b0001: t_of = T1C;
            4'b0010: t_of = T2C;
            4'b0100: t_of = T3AC;
            default: t_of = TcC;
        endcase
    endfunction

    function automatic logic in_win(input logic [CW-1:0] c, input logic [CW-1:0] s);
        in_win = (c >= s) && (c < s + PwC);
    endfunction

    always_comb begin
        // A launch is either a sequence start (mode leaves 0) or the slot after a stop tick.
        launch  = (bus.mode != 4'd0) && (stop_dly_q || (mode_prev_q == 4'd0));
        one_hot = (bus.mode & (bus.mode - 4'd1)) == 4'd0;

        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_tag_d  = mode_tag_q;
        phase_tag_d = phase_tag_q;
        sls_d       = sls_q;
        err_d       = 1'b0;
        overrun_d   = 1'b0;
        tm_q        = t_of(mode_tag_q);

        case (state_q)
            StIdle: begin
                if (launch) begin
                    if (one_hot) begin
                        state_d     = StEmit;
                        cnt_d       = Zero;
                        mode_tag_d  = bus.mode;
                        phase_tag_d = bus.oddeven;
                        sls_d       = bus.sls_en;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                overrun_d = launch;
                if (cnt_q == tm_q + PwC - One) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StDone: begin
                overrun_d = launch;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Pulse outputs are registered from next-state so they align with busy and cnt.
        tm_d  = t_of(mode_tag_d);
        p13_d = (state_d == StEmit) && (in_win(cnt_d, Zero) || in_win(cnt_d, tm_d));
        p2_d  = (state_d == StEmit) && sls_d && in_win(cnt_d, P2C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= Zero;
            mode_tag_q  <= 4'd0;
            phase_tag_q <= 1'b0;
            sls_q       <= 1'b0;
            stop_dly_q  <= 1'b0;
            mode_prev_q <= 4'd0;
            p13_q       <= 1'b0;
            p2_q        <= 1'b0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_tag_q  <= mode_tag_d;
            phase_tag_q <= phase_tag_d;
            sls_q       <= sls_d;
            stop_dly_q  <= bus.stop;
            mode_prev_q <= bus.mode;
            p13_q       <= p13_d;
            p2_q        <= p2_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.p13       = p13_q;
    assign bus.p2        = p2_q;
    assign bus.busy      = (state_q == StEmit);
    assign bus.done      = (state_q == StDone);
    assign bus.mode_tag  = mode_tag_q;
    assign bus.phase_tag = phase_tag_q;
    assign bus.err       = err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ssr_interrogation_encoder.sv
// Scoreboard bench for ssr_interrogation_encoder: a cycle-count model predicts frames and
// err/overrun events; a negedge monitor measures each frame and compares.
module tb_ssr_interrogation_encoder;

    localparam int PW = 16, P2_OFF = 40, T1 = 60, T2 = 100, T3A = 160, TC = 420;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssr_interrogation_encoder_if bus();

    ssr_interrogation_encoder #(
        .PW(PW), .P2_OFF(P2_OFF), .T1(T1), .T2(T2), .T3A(T3A), .TC(TC), .CW(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] mode;
        logic       phase;
        int         p3;
        int         p2;
        int         len;
    } frame_t;

    frame_t exp_q[$];
    int     evt_q[$];   // 1 = err, 2 = overrun
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int tm_of(input logic [3:0] m);
        if (m == 4'b0001) return T1;
        if (m == 4'b0010) return T2;
        if (m == 4'b0100) return T3A;
        return TC;
    endfunction

    // Reference model: a frame launched in cycle n keeps the encoder unavailable until n+Tm+PW+2.
    int         cyc = 0;
    int         idle_at = 0;
    logic [3:0] prev_mode = 4'd0;
    logic       prev_stop = 1'b0;

    task automatic step(input logic [3:0] m, input logic oe, input logic st, input logic sls);
        bus.mode = m; bus.oddeven = oe; bus.stop = st; bus.sls_en = sls;
        if (m != 4'd0 && (prev_stop || prev_mode == 4'd0)) begin
            if (cyc < idle_at) evt_q.push_back(2);
            else if ($countones(m) != 1) evt_q.push_back(1);
            else begin
                frame_t f;
                f.mode = m; f.phase = oe; f.p3 = tm_of(m);
                f.p2 = sls ? P2_OFF : -1; f.len = tm_of(m) + PW;
                exp_q.push_back(f);
                idle_at = cyc + tm_of(m) + PW + 2;
            end
        end
        prev_mode = m; prev_stop = st; cyc++;
        @(posedge clk); #1;
    endtask

    task automatic slot(input logic [3:0] m, input logic oe, input int len, input logic sls);
        for (int c = 0; c < len; c++) step(m, oe, (c == len - 1), sls);
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) step(4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p13"}, bus.p13, 0);
        check({tag, "_p2"}, bus.p2, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_mode_tag"}, bus.mode_tag, 0);
        check({tag, "_phase_tag"}, bus.phase_tag, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
    endtask

    // Monitor
    logic   active = 1'b0, done_chk = 1'b0, p13_prev, p2_prev;
    int     rel, p13_rises, p13_cnt, p1_at, p3_at, p2_at, p2_cnt, got;
    frame_t mf;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            active = 1'b0; done_chk = 1'b0;
            continue;
        end
        if (done_chk) begin
            check("done_one_cycle", bus.done, 0);
            done_chk = 1'b0;
        end
        if (bus.err || bus.overrun) begin
            got = bus.overrun ? 2 : 1;
            check("err_overrun_exclusive", bus.err & bus.overrun, 0);
            if (evt_q.size() == 0) check("unexpected_event", got, 0);
            else check("event_kind", got, evt_q.pop_front());
        end
        if (bus.busy) begin
            if (!active) begin
                active = 1'b1; rel = 0; p13_prev = 1'b0; p2_prev = 1'b0;
                p13_rises = 0; p13_cnt = 0; p1_at = -1; p3_at = -1; p2_at = -1; p2_cnt = 0;
            end
            if (bus.p13) begin
                if (!p13_prev) begin
                    if (p13_rises == 0) p1_at = rel;
                    else if (p13_rises == 1) p3_at = rel;
                    p13_rises++;
                end
                p13_cnt++;
            end
            if (bus.p2) begin
                if (!p2_prev) p2_at = rel;
                p2_cnt++;
            end
            p13_prev = bus.p13; p2_prev = bus.p2; rel++;
        end else if (active) begin
            active = 1'b0;
            check("done_after_busy", bus.done, 1);
            done_chk = 1'b1;
            if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
            else begin
                mf = exp_q.pop_front();
                check("p1_lead", p1_at, 0);
                check("p3_lead", p3_at, mf.p3);
                check("p13_rises", p13_rises, 2);
                check("p13_width_total", p13_cnt, 2 * PW);
                check("p2_lead", p2_at, mf.p2);
                check("p2_width", p2_cnt, (mf.p2 < 0) ? 0 : PW);
                check("busy_len", rel, mf.len);
                check("mode_tag", bus.mode_tag, mf.mode);
                check("phase_tag", bus.phase_tag, mf.phase);
            end
        end else begin
            check("idle_pulses", bus.p13 | bus.p2, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seqm [4];
        logic [3:0] rm;
        seqm[0] = 4'b0001; seqm[1] = 4'b0010; seqm[2] = 4'b0100; seqm[3] = 4'b1000;
        bus.mode = 4'd0; bus.oddeven = 1'b0; bus.stop = 1'b0; bus.sls_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(3);

        // Mode 1 with P2, then mode C without P2
        slot(4'b0001, 1'b0, 80, 1'b1);
        idle(5);
        slot(4'b1000, 1'($urandom_range(0, 1)), 440, 1'b0);
        idle(3);

        // Full sequencer run: 1,1,2,2,3A,3A,C,C with alternating phase
        for (int i = 0; i < 8; i++)
            slot(seqm[i / 2], 1'(i % 2), 440 + int'($urandom_range(0, 30)), 1'b1);
        idle(5);

        // Non-one-hot launch
        slot(4'b0011, 1'b0, 5, 1'b0);
        idle(3);

        // Forced re-launch at cnt 30 of a mode-2 frame
        for (int c = 0; c < 30; c++) step(4'b0010, 1'b0, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 90; c++) step(4'b0010, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Async reset at cnt 65 of a mode-1 frame (inside P3)
        for (int c = 0; c < 66; c++) step(4'b0001, 1'b0, 1'b0, 1'b1);
        check("pre_reset_p13", bus.p13, 1);
        bus.mode = 4'd0; bus.stop = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("midframe_reset");
        exp_q.delete(); evt_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        prev_mode = 4'd0; prev_stop = 1'b0; idle_at = cyc;
        idle(2);
        slot(4'b0100, 1'b1, 200, 1'b0);
        idle(5);

        // Random slots, occasional invalid mode and short slots causing overrun
        for (int r = 0; r < 8; r++) begin
            rm = seqm[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) rm = 4'b0110;
            for (int s = 0; s < 2; s++)
                slot(rm, 1'(s), int'($urandom_range(50, 480)), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(1, 10)));
        end

        idle(500);
        check("exp_frames_drained", exp_q.size(), 0);
        check("exp_events_drained", evt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
